reaction_timer_core: RTL
========================

Name: reaction_timer_core

Overview:
Parametrised successor to the single-configuration starting-lights/reaction-timer chain. It integrates the ms tick generation, light sequencing, LFSR random hold, reaction counting, false-start detection, timeout and best-time tracking in one block on a single system clock. Light count, light step period, hold granularity, LFSR width/taps and counter width are all parameters. It drives LEDR-style light outputs directly and feeds a binary reaction time to the existing BCD/7-seg display path.

Parameters:
CLK_PER_MS, 50000, clk cycles per 1 ms tick (>=2)
N_LIGHTS, 10, number of start lights (>=2)
LIGHT_MS, 500, ms between successive lights turning on
DELAY_BITS, 5, LFSR width
TAP_1, 5, LFSR feedback stage (1-indexed)
TAP_2, 3, LFSR feedback stage (1-indexed)
HOLD_UNIT_MS, 100, ms per LFSR count of random hold
COUNT_BITS, 16, reaction counter width

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
start  input  1  start request, single-cycle pulse, already synchronised/debounced
stop  input  1  driver reaction, single-cycle pulse, already synchronised/debounced
clear_best  input  1  set best_ms to all-ones
lights  output  N_LIGHTS  start lights, bit0 lights first
reaction_ms  output  COUNT_BITS  last reaction time in ms
best_ms  output  COUNT_BITS  best valid reaction time
result_valid  output  1  reaction_ms holds a fresh valid result
false_start  output  1  stop seen before lights out
timeout  output  1  counter saturated without stop
busy  output  1  high in LIGHTS, HOLD, TIMING

Behaviour:
- Reset (async, rst=1): state IDLE; lights=0; reaction_ms=0; best_ms=all-ones; result_valid=false_start=timeout=0; ms prescaler=0; LFSR=1 (nonzero seed).
- ms tick: free-running prescaler 0..CLK_PER_MS-1; tick is an internal 1-cycle strobe when the prescaler equals CLK_PER_MS-1. It is not restarted by start.
- LFSR: advances every clk cycle. feedback = q[TAP_1-1]^q[TAP_2-1]; q <= {q[DELAY_BITS-2:0], feedback}. It never reaches 0.
- States are IDLE, LIGHTS, HOLD, TIMING, DONE, FALSE.
- Transition from IDLE/DONE/FALSE on start:
  - Go to LIGHTS.
  - Clear lights, step counter, result_valid, false_start and timeout.
  - reaction_ms and best_ms are kept.
- LIGHTS:
  - Count ms ticks.
  - Every LIGHT_MS ticks, lights <= {lights[N-2:0],1'b1}.
  - On the tick where lights become all-ones: sample the LFSR value P, load the hold counter with P*HOLD_UNIT_MS, and go to HOLD.
- HOLD:
  - Decrement the hold counter on each tick.
  - On reaching 0: lights=0, reaction counter=0, go to TIMING.
  - Hold length is therefore in the range HOLD_UNIT_MS..(2^DELAY_BITS-1)*HOLD_UNIT_MS ms.
- TIMING:
  - The counter increments on each tick.
  - On stop: reaction_ms <= counter, result_valid=1, go to DONE.
  - best_ms <= min(best_ms, counter), evaluated with the latched value in the same cycle.
  - If stop and tick coincide, the pre-increment count is latched.
- Timeout:
  - In TIMING, if the counter equals all-ones at a tick, go to DONE with reaction_ms=all-ones, timeout=1 and result_valid=0.
  - best_ms is not updated.
- False start:
  - stop in LIGHTS or HOLD sets false_start=1 and lights=0, then goes to FALSE.
  - reaction_ms and best_ms are unchanged.
- Ignored inputs:
  - stop is ignored in IDLE, DONE and FALSE.
  - start is ignored in LIGHTS, HOLD and TIMING (no restart mid-run).
- Simultaneous inputs:
  - start and stop in the same cycle: in LIGHTS/HOLD, stop wins (false start); in IDLE/DONE/FALSE, start wins.
- clear_best:
  - Sets best_ms=all-ones in any state.
  - If it coincides with a valid stop, the new result is written (result overrides the clear).
- busy = (state in LIGHTS, HOLD, TIMING).
- All outputs are registered; output latency after the causing event is 1 clk.

Test Plan:
Parameters for all scenarios: CLK_PER_MS=4, N_LIGHTS=4, LIGHT_MS=2, DELAY_BITS=3, TAP_1=3, TAP_2=2, HOLD_UNIT_MS=1, COUNT_BITS=8.
1. Reset mid-TIMING:
   - Assert rst asynchronously (not on a clk edge).
   - Required: all outputs return immediately to their reset values, best_ms=255, lights=0.
2. Normal run:
   - Pulse start; record the lights sequence.
   - Required: lights show 0001, 0011, 0111, 1111, each 8 clk apart.
   - Required: lights=0 after P ticks, where P is the sampled LFSR value (1..7).
   - Pulse stop 5 ticks later -> reaction_ms=5, result_valid=1, best_ms=5.
3. Second run:
   - Stop after 9 ticks -> reaction_ms=9 and best_ms stays 5.
   - Third run stops at 3 ticks -> best_ms=3.
4. False start:
   - stop while lights=0011 -> false_start=1, lights=0, state FALSE.
   - reaction_ms and best_ms are unchanged.
   - A later start clears false_start.
5. Timeout:
   - No stop for 255 ticks in TIMING -> timeout=1, reaction_ms=255, result_valid=0, best_ms unchanged.
6. Corner events:
   - start during TIMING is ignored.
   - start+stop in the same cycle in HOLD -> false start.
   - stop coinciding with a tick at count 4 -> reaction_ms=4.
   - clear_best in IDLE -> best_ms=255.

Source files
------------

// File: rtl/reaction_timer_core.sv
// reaction_timer_core
//   Starting-lights / reaction-timer engine on a single system clock.
//   A free-running prescaler produces a 1 ms tick. On start the lights fill
//   one by one every LIGHT_MS ticks. Once all are lit, a random hold of
//   (LFSR value * HOLD_UNIT_MS) ticks follows, then the lights go out and the
//   reaction counter runs until stop. The block also flags false starts
//   (stop before lights out) and timeouts (counter saturates), and it tracks
//   the best valid reaction time.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   start        start request pulse (ignored while a run is in progress)
//   stop         driver reaction pulse
//   clear_best   force best_ms to all-ones
//   lights       start lights, bit0 lights first
//   reaction_ms  last reaction time (all-ones after a timeout)
//   best_ms      best valid reaction time
//   result_valid reaction_ms holds a fresh valid result
//   false_start  stop arrived before lights out
//   timeout      counter saturated without a stop
//   busy         run in progress (LIGHTS, HOLD, TIMING)
module reaction_timer_core #(
    parameter int CLK_PER_MS   = 50000,
    parameter int N_LIGHTS     = 10,
    parameter int LIGHT_MS     = 500,
    parameter int DELAY_BITS   = 5,
    parameter int TAP_1        = 5,
    parameter int TAP_2        = 3,
    parameter int HOLD_UNIT_MS = 100,
    parameter int COUNT_BITS   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear_best,
    output logic [N_LIGHTS-1:0]   lights,
    output logic [COUNT_BITS-1:0] reaction_ms,
    output logic [COUNT_BITS-1:0] best_ms,
    output logic                  result_valid,
    output logic                  false_start,
    output logic                  timeout,
    output logic                  busy
);

    localparam int PRESC_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int STEP_W  = $clog2(LIGHT_MS + 1);
    // Wide enough for (2^DELAY_BITS-1) * HOLD_UNIT_MS.
    localparam int HOLD_W  = DELAY_BITS + $clog2(HOLD_UNIT_MS + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LIGHTS = 3'd1,
        S_HOLD   = 3'd2,
        S_TIMING = 3'd3,
        S_DONE   = 3'd4,
        S_FALSE  = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [PRESC_W-1:0]     presc_q;
    logic [DELAY_BITS-1:0]  lfsr_q;
    logic [STEP_W-1:0]      step_q, step_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [COUNT_BITS-1:0]  cnt_q, cnt_d;
    logic [N_LIGHTS-1:0]    lights_q, lights_d;
    logic [COUNT_BITS-1:0]  reaction_q, reaction_d;
    logic [COUNT_BITS-1:0]  best_q, best_d;
    logic                   valid_q, valid_d;
    logic                   fs_q, fs_d;
    logic                   to_q, to_d;
    logic                   busy_q, busy_d;

    logic                   tick_s;
    logic                   lfsr_fb_s;
    logic [N_LIGHTS-1:0]    lights_sh_s;

    assign tick_s      = (presc_q == PRESC_W'(CLK_PER_MS - 1));
    assign lfsr_fb_s   = lfsr_q[TAP_1-1] ^ lfsr_q[TAP_2-1];
    assign lights_sh_s = {lights_q[N_LIGHTS-2:0], 1'b1};

    // Free-running ms prescaler; never restarted by start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
        end else if (tick_s) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    // LFSR advancing every cycle; the nonzero seed keeps it off the all-zero lockup state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= DELAY_BITS'(1);
        end else begin
            lfsr_q <= {lfsr_q[DELAY_BITS-2:0], lfsr_fb_s};
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            step_q     <= '0;
            hold_q     <= '0;
            cnt_q      <= '0;
            lights_q   <= '0;
            reaction_q <= '0;
            best_q     <= '1;
            valid_q    <= 1'b0;
            fs_q       <= 1'b0;
            to_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            hold_q     <= hold_d;
            cnt_q      <= cnt_d;
            lights_q   <= lights_d;
            reaction_q <= reaction_d;
            best_q     <= best_d;
            valid_q    <= valid_d;
            fs_q       <= fs_d;
            to_q       <= to_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        hold_d     = hold_q;
        cnt_d      = cnt_q;
        lights_d   = lights_q;
        reaction_d = reaction_q;
        best_d     = best_q;
        valid_d    = valid_q;
        fs_d       = fs_q;
        to_d       = to_q;

        // A valid stop below overrides this clear with the new result.
        if (clear_best) begin
            best_d = '1;
        end else begin
            best_d = best_q;
        end

        case (state_q)
            S_IDLE, S_DONE, S_FALSE: begin
                if (start) begin
                    state_d  = S_LIGHTS;
                    lights_d = '0;
                    step_d   = '0;
                    valid_d  = 1'b0;
                    fs_d     = 1'b0;
                    to_d     = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_LIGHTS: begin
                if (stop) begin
                    state_d  = S_FALSE;
                    fs_d     = 1'b1;
                    lights_d = '0;
                end else if (tick_s) begin
                    if (step_q == STEP_W'(LIGHT_MS - 1)) begin
                        step_d   = '0;
                        lights_d = lights_sh_s;
                        if (&lights_sh_s) begin
                            hold_d  = HOLD_W'(lfsr_q) * HOLD_W'(HOLD_UNIT_MS);
                            state_d = S_HOLD;
                        end else begin
                            state_d = S_LIGHTS;
                        end
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end else begin
                    state_d = S_LIGHTS;
                end
            end
            S_HOLD: begin
                if (stop) begin
                    state_d  = S_FALSE;
                    fs_d     = 1'b1;
                    lights_d = '0;
                end else if (tick_s) begin
                    // Hold is at least 1 since the LFSR never holds 0.
                    if (hold_q <= HOLD_W'(1)) begin
                        hold_d   = '0;
                        lights_d = '0;
                        cnt_d    = '0;
                        state_d  = S_TIMING;
                    end else begin
                        hold_d = hold_q - 1'b1;
                    end
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_TIMING: begin
                // stop has priority over a coincident tick: latch the pre-increment count.
                if (stop) begin
                    reaction_d = cnt_q;
                    valid_d    = 1'b1;
                    state_d    = S_DONE;
                    if (clear_best || (cnt_q < best_q)) begin
                        best_d = cnt_q;
                    end else begin
                        best_d = best_q;
                    end
                end else if (tick_s) begin
                    if (&cnt_q) begin
                        reaction_d = '1;
                        to_d       = 1'b1;
                        valid_d    = 1'b0;
                        state_d    = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    state_d = S_TIMING;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_LIGHTS) || (state_d == S_HOLD) || (state_d == S_TIMING);
    end

    assign lights       = lights_q;
    assign reaction_ms  = reaction_q;
    assign best_ms      = best_q;
    assign result_valid = valid_q;
    assign false_start  = fs_q;
    assign timeout      = to_q;
    assign busy         = busy_q;

endmodule
